kbd_key_sequencer: RTL

KBD_KEY_SEQUENCER -- requirements
Module: kbd_key_sequencer

---
 rtl/kbd_key_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/kbd_key_sequencer.sv
// PS/2 scancode sequencer: tracks make/break/extended/shift prefixes, looks each
// make code up in an external registered ASCII table and queues the result in a FIFO.
module kbd_key_sequencer #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sc_valid,
  input  logic [7:0] sc_data,
  output logic       sc_ready,
  output logic [7:0] lk_code,
  input  logic [7:0] lk_ascii,
  output logic       key_valid,
  output logic [7:0] key_data,
  input  logic       key_ready,
  output logic [7:0] held_code,
  output logic [7:0] key_count,
  output logic       overflow,
  output logic [1:0] state_dbg
);

  // Handshakes: a transfer happens on a posedge where valid and ready are both
  // high; valid never depends on ready, ready is a pure function of local state.

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BREAK = 2'd1,
    LOOK  = 2'd2,
    CAPT  = 2'd3
  } state_t;

  state_t     state, state_nx;
  logic       ext, ext_nx;
  logic       shift, shift_nx;
  logic [7:0] held, held_nx;
  logic [7:0] latch, latch_nx;
  logic       cap_push;
  logic [7:0] cap_data;
  logic       accept;
  logic       is_shift_code;

  logic       push_vld;
  logic [7:0] push_data;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ;
  logic          full, do_push, do_pop;

  assign sc_ready      = (state == IDLE) || (state == BREAK);
  assign accept        = sc_valid && sc_ready;
  assign is_shift_code = (sc_data == 8'h12) || (sc_data == 8'h59);
  assign lk_code       = ((state == LOOK) || (state == CAPT)) ? latch : 8'h00;
  assign held_code     = held;
  assign state_dbg     = state;

  always_comb begin
    state_nx = state;
    ext_nx   = ext;
    shift_nx = shift;
    held_nx  = held;
    latch_nx = latch;
    cap_push = 1'b0;
    cap_data = lk_ascii;
    if (shift && (lk_ascii >= 8'h61) && (lk_ascii <= 8'h7A)) begin
      cap_data = lk_ascii - 8'h20;
    end
    case (state)
      IDLE: begin
        if (accept) begin
          if (sc_data == 8'hF0) begin
            state_nx = BREAK;
          end else if (sc_data == 8'hE0) begin
            ext_nx = 1'b1;
          end else if (ext) begin
            // Extended keys are swallowed entirely.
            ext_nx = 1'b0;
          end else if (is_shift_code) begin
            shift_nx = 1'b1;
          end else begin
            latch_nx = sc_data;
            held_nx  = sc_data;
            state_nx = LOOK;
          end
        end
      end
      BREAK: begin
        if (accept) begin
          ext_nx = 1'b0;
          if (is_shift_code) shift_nx = 1'b0;
          if (sc_data == held) held_nx = 8'h00;
          state_nx = IDLE;
        end
      end
      LOOK: state_nx = CAPT;
      CAPT: begin
        cap_push = (lk_ascii != 8'h00);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ext       <= 1'b0;
      shift     <= 1'b0;
      held      <= 8'h00;
      latch     <= 8'h00;
      push_vld  <= 1'b0;
      push_data <= 8'h00;
    end else begin
      state     <= state_nx;
      ext       <= ext_nx;
      shift     <= shift_nx;
      held      <= held_nx;
      latch     <= latch_nx;
      push_vld  <= cap_push;
      push_data <= cap_data;
    end
  end

  // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
  assign full      = (occ == DEPTH_L);
  assign key_valid = (occ != '0);
  assign do_pop    = key_valid && key_ready;
  assign do_push   = push_vld && (!full || do_pop);
  assign key_data  = key_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      key_count <= 8'h00;
      overflow  <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr    <= wr_ptr + 1'b1;
        key_count <= key_count + 8'h01;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (push_vld && !do_push) overflow <= 1'b1;
    end
  end

endmodule
